// File: rtl/md5_view_ctrl.sv
// md5_view_ctrl: sequences the 16-position digest window after each hash
// and arbitrates debounced buttons against an auto-scroll timer.
module md5_view_ctrl #(
    parameter int DEB_CYCLES = 250000,
    parameter int SCROLL_DIV = 50000000,
    parameter int NPOS       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_capture,
    input  logic       auto_en,
    input  logic       hash_start,
    input  logic       digest_valid,
    output logic       start,
    output logic       capture,
    output logic       left_shift,
    output logic       right_shift,
    output logic       win_clr,
    output logic [3:0] pos
);
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [3:0]    LAST    = 4'(NPOS - 1);
    localparam logic [DW-1:0] DEB_END = DW'(DEB_CYCLES - 1);
    localparam logic [SW-1:0] SCR_END = SW'(SCROLL_DIV - 1);

    typedef enum logic [1:0] {BROWSE, HASH, FILL, REWIND} state_t;
    state_t state;

    logic [2:0]    sync1, sync2, level, level_q;
    logic [DW-1:0] dcnt [3];
    logic [SW-1:0] scnt;
    logic [2:0]    ev;
    logic          any_ev, tick, at_last, at_first;

    // bit 0 = left, bit 1 = right, bit 2 = capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_q <= '0;
            for (int i = 0; i < 3; i++) dcnt[i] <= '0;
        end else begin
            sync1   <= {btn_capture, btn_right, btn_left};
            sync2   <= sync1;
            level_q <= level;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == level[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DEB_END) begin
                    level[i] <= sync2[i];
                    dcnt[i]  <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + DW'(1);
                end
            end
        end
    end

    assign ev       = level & ~level_q;
    assign any_ev   = |ev;
    assign at_last  = (pos == LAST);
    assign at_first = (pos == 4'd0);
    assign tick     = (state == BROWSE) && auto_en && (scnt == SCR_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt <= '0;
        end else if (state == BROWSE && auto_en) begin
            scnt <= (scnt == SCR_END) ? '0 : scnt + SW'(1);
        end else begin
            scnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BROWSE;
            start       <= 1'b0;
            capture     <= 1'b0;
            left_shift  <= 1'b0;
            right_shift <= 1'b0;
            win_clr     <= 1'b0;
            pos         <= 4'd0;
        end else begin
            capture     <= 1'b0;
            left_shift  <= 1'b0;
            right_shift <= 1'b0;
            win_clr     <= 1'b0;
            if (hash_start) begin
                state   <= HASH;
                start   <= 1'b1;
                win_clr <= 1'b1;
                pos     <= 4'd0;
            end else begin
                unique case (state)
                    HASH: begin
                        if (digest_valid) begin
                            state <= FILL;
                            start <= 1'b0;
                        end
                    end
                    FILL: begin
                        capture <= 1'b1;
                        if (!at_last) begin
                            left_shift <= 1'b1;
                            pos        <= pos + 4'd1;
                        end else begin
                            state <= REWIND;
                        end
                    end
                    REWIND: begin
                        if (!at_first) begin
                            right_shift <= 1'b1;
                            pos         <= pos - 4'd1;
                        end else begin
                            state <= BROWSE;
                        end
                    end
                    BROWSE: begin
                        capture <= ev[2];
                        // simultaneous left+right cancels; ticks yield to buttons
                        if (ev[0] && !ev[1] && !at_last) begin
                            left_shift <= 1'b1;
                            pos        <= pos + 4'd1;
                        end else if (ev[1] && !ev[0] && !at_first) begin
                            right_shift <= 1'b1;
                            pos         <= pos - 4'd1;
                        end else if (tick && !any_ev) begin
                            if (!at_last) begin
                                left_shift <= 1'b1;
                                pos        <= pos + 4'd1;
                            end else begin
                                state <= REWIND;
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/md5_view_ctrl.md
Name: md5_view_ctrl

Overview:
- Sequencer and input arbiter for the 16-position digest display window, which shows 128-bit data as six 5-bit digit codes.
- Drives the window's start, capture, left_shift and right_shift controls and its clear.
- Debounces three user buttons and arbitrates them against an auto-scroll timer.
- After each MD5 completion, automatically captures all 16 window positions and rewinds the window to position 0.

Parameters:
DEB_CYCLES, 250000, consecutive stable cycles required before a debounced button level changes
SCROLL_DIV, 50000000, clock cycles between auto-scroll ticks
NPOS, 16, number of window positions (pos range 0..NPOS-1)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  reset, asynchronous, active-high
btn_left  in  1  raw left button, asynchronous to clk
btn_right  in  1  raw right button, asynchronous to clk
btn_capture  in  1  raw capture button, asynchronous to clk
auto_en  in  1  enables auto-scroll in BROWSE state
hash_start  in  1  one-cycle pulse: MD5 core has started a new message
digest_valid  in  1  one-cycle pulse: MD5 digest is stable on the window data bus
start  out  1  window freeze, 1 only in HASH state
capture  out  1  one-cycle capture pulse to window
left_shift  out  1  one-cycle shift pulse, pos+1
right_shift  out  1  one-cycle shift pulse, pos-1
win_clr  out  1  one-cycle synchronous clear to window
pos  out  4  mirrored window position 0..15

Behaviour:
- Reset (async):
  - state=BROWSE, pos=0, start=0; capture, left_shift, right_shift and win_clr=0.
  - Debounced levels=0; both counters=0.
- All outputs are registered. At most one of left_shift/right_shift is asserted per cycle.
- Debounce, per button:
  - Raw input passes through a 2-flop synchronizer.
  - The debounced level takes the synced value after DEB_CYCLES consecutive cycles in which the synced value differs from the debounced level.
  - Any agreeing cycle resets the counter.
  - A 0->1 transition of the debounced level produces an internal event.
  - Raw edge to output pulse = 2 + DEB_CYCLES + 1 cycles.
- pos mirror:
  - Increments on each issued left_shift and decrements on each issued right_shift.
  - A left_shift is never issued at pos=15; a right_shift is never issued at pos=0.
- States:
  - HASH:
    - start=1; all pulses 0.
    - digest_valid -> FILL, pos unchanged.
  - FILL:
    - Each cycle: capture=1.
    - If pos<15: left_shift=1, remain in FILL.
    - At pos=15: capture only, left_shift=0, next state REWIND.
    - Exactly 16 capture pulses are issued.
  - REWIND:
    - right_shift=1 each cycle while pos>0.
    - When pos=0: no pulse, next state BROWSE.
    - Button events are discarded in REWIND.
  - BROWSE, in priority order:
    1. Left and right events in the same cycle: both ignored.
    2. Left event: left_shift if pos<15, else none.
    3. Right event: right_shift if pos>0, else none.
    4. Capture event: capture; may coincide with a shift in the same cycle.
    5. Auto tick, only if auto_en and no button event this cycle:
       - pos<15: left_shift.
       - pos=15: go to REWIND (wrap to 0).
       - A tick coinciding with a button event is dropped.
- Scroll timer:
  - Counts 0..SCROLL_DIV-1 in BROWSE while auto_en=1; the tick fires at terminal count.
  - Held at 0 when auto_en=0 or when not in BROWSE.
- hash_start, in any state:
  - Next state HASH, win_clr=1 for exactly one cycle, pos=0.
  - Any pulse scheduled that cycle is suppressed.
  - hash_start has priority over digest_valid in the same cycle.
- digest_valid outside HASH is ignored.
- rst mid-FILL or mid-REWIND: immediate return to the reset values; no further pulses.

Test Plan:
1. Reset, hash_start, 10 idle cycles, digest_valid -> win_clr for 1 cycle, start=1 until digest_valid. Then 16 captures with 15 left_shifts (pos 0->15), 15 right_shifts (pos 15->0), state BROWSE, start=0.
2. DEB_CYCLES=4: btn_left high 3 cycles then low -> no pulse. Held 10 cycles -> exactly one left_shift 7 cycles after the raw edge, pos=1. Right at pos=0 -> no pulse.
3. BROWSE at pos=15, left press -> no pulse, pos stays 15. Left and right debounced in the same cycle -> neither shift, pos unchanged.
4. SCROLL_DIV=8, auto_en=1 -> left_shift every 8 cycles to pos=15. Next tick -> 15 consecutive right_shifts to pos=0, then scrolling resumes. A tick coinciding with a capture event -> capture only.
5. hash_start at FILL pos=7 -> win_clr pulse, pos=0, start=1, no capture that cycle. rst asserted asynchronously mid-REWIND -> all outputs 0, pos=0, before the next clk edge.
